// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multi-word sequential adder.
//   state_e   : FSM encodings (IDLE, RUN, DONE)
//   idx_width : width of the slice index register, never below 1 bit
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-slice configuration still keeps a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for multiword_add_sequencer.
//   in_valid/in_ready   : operand-set handshake (in_a, in_b, in_cin)
//   out_valid/out_ready : result handshake (out_sum, out_cout, out_ovf)
// Modports: master = producer/consumer side, slave = the adder block.
interface multiword_add_sequencer_if #(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 4
);
  localparam int OPW = CHUNK_W * NUM_CHUNKS;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_a;
  logic [OPW-1:0] in_b;
  logic           in_cin;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_sum;
  logic           out_cout;
  logic           out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/parameterized_full_adder.sv
// Combinational WIDTH-bit adder with carry in and carry out.
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : sum modulo 2^WIDTH
//   cout_o   : carry out of the top bit
module parameterized_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide-operand adder that walks one CHUNK_W slice per cycle, least
// significant first, through a single CHUNK_W adder and keeps the carry
// in a register between slices.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of multiword_add_sequencer_if (operands in,
//           sum/carry/overflow out, valid/ready on both sides)
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiword_add_sequencer_if.slave  bus
);

  localparam int OPW   = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e             state_q;
  logic [OPW-1:0]     a_q;
  logic [OPW-1:0]     b_q;
  logic [OPW-1:0]     sum_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;

  int                 sel;
  logic [CHUNK_W-1:0] a_slice;
  logic [CHUNK_W-1:0] b_slice;
  logic [CHUNK_W-1:0] add_sum;
  logic               add_cout;

  // Slice mux: idx_q picks the CHUNK_W window fed to the shared adder.
  always_comb begin
    sel     = int'(idx_q) * CHUNK_W;
    a_slice = a_q[sel +: CHUNK_W];
    b_slice = b_q[sel +: CHUNK_W];
  end

  parameterized_full_adder #(
    .WIDTH (CHUNK_W)
  ) u_adder (
    .a_i    (a_slice),
    .b_i    (b_slice),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is high whenever we sit in IDLE out of reset.
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[sel +: CHUNK_W] <= add_sum;
          carry_q               <= add_cout;
          // idx stays on the top slice so DONE never indexes past OPW.
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign bus.out_ovf   = (a_q[OPW-1] == b_q[OPW-1]) && (sum_q[OPW-1] != a_q[OPW-1]);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multiword_add_sequencer_if #(.CHUNK_W(8), .NUM_CHUNKS(4)) bus4 ();
  multiword_add_sequencer_if #(.CHUNK_W(8), .NUM_CHUNKS(1)) bus1 ();

  multiword_add_sequencer #(.CHUNK_W(8), .NUM_CHUNKS(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  multiword_add_sequencer #(.CHUNK_W(8), .NUM_CHUNKS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge following the accept edge; steps through the
  // four RUN edges and ends at the negedge right after out_valid rises.
  task automatic wait_done4(input string tag);
    for (int k = 1; k <= 4; k++) begin
      chk({tag, "_valid_lo"}, 64'(bus4.out_valid), 64'd0);
      @(negedge clk);
    end
    chk({tag, "_valid_hi"}, 64'(bus4.out_valid), 64'd1);
  endtask

  task automatic accept4(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus4.in_ready), 64'd1);
    bus4.in_valid = 1'b1;
    bus4.in_a     = a;
    bus4.in_b     = b;
    bus4.in_cin   = cin;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.in_a     = ~a;
    bus4.in_b     = ~b;
    wait_done4(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
    bus1.out_ready = 1'b1;

    // 1: reset held for 3 cycles while inputs toggle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus4.in_valid = ~bus4.in_valid;
      bus4.in_a     = 32'hA5A5_0000 + 32'(i);
      bus4.in_b     = 32'h5A5A_FFFF;
      bus4.in_cin   = ~bus4.in_cin;
      bus4.out_ready = ~bus4.out_ready;
      #1;
      chk("rst_in_ready", 64'(bus4.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      chk("rst_out_sum", 64'(bus4.out_sum), 64'd0);
      chk("rst_cout_ovf", {62'd0, bus4.out_cout, bus4.out_ovf}, 64'd0);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0; bus4.in_cin = 1'b0; bus4.out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(bus4.in_ready), 64'd1);
    chk("rel_out_valid", 64'(bus4.out_valid), 64'd0);
    chk("rel_in_ready_n1", 64'(bus1.in_ready), 64'd1);

    // 2: full carry ripple across all slices
    accept4("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("t2_sum", 64'(bus4.out_sum), 64'h0000_0000);
    chk("t2_cout", 64'(bus4.out_cout), 64'd1);
    chk("t2_ovf", 64'(bus4.out_ovf), 64'd0);
    @(negedge clk);
    chk("t2_valid_one_cycle", 64'(bus4.out_valid), 64'd0);

    // 3: signed overflow cases
    accept4("t3a", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    chk("t3a_sum", 64'(bus4.out_sum), 64'h8000_0000);
    chk("t3a_cout", 64'(bus4.out_cout), 64'd0);
    chk("t3a_ovf", 64'(bus4.out_ovf), 64'd1);
    accept4("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("t3b_sum", 64'(bus4.out_sum), 64'h0000_0000);
    chk("t3b_cout", 64'(bus4.out_cout), 64'd1);
    chk("t3b_ovf", 64'(bus4.out_ovf), 64'd1);

    // 4: backpressure, then back-to-back accept right after handshake
    @(negedge clk);
    bus4.out_ready = 1'b0;
    accept4("t4", 32'h00FF_00FF, 32'h0001_0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_sum", 64'(bus4.out_sum), 64'h0100_0100);
      chk("t4_hold_valid", 64'(bus4.out_valid), 64'd1);
      chk("t4_hold_in_ready", 64'(bus4.in_ready), 64'd0);
      chk("t4_hold_cout_ovf", {62'd0, bus4.out_cout, bus4.out_ovf}, 64'd0);
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_a      = 32'h0000_0001;
    bus4.in_b      = 32'h0000_0002;
    bus4.in_cin    = 1'b0;
    chk("t4_in_ready_in_done", 64'(bus4.in_ready), 64'd0);
    @(negedge clk);
    chk("t4_post_hs_valid", 64'(bus4.out_valid), 64'd0);
    chk("t4_post_hs_in_ready", 64'(bus4.in_ready), 64'd1);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    chk("t4_accepted", 64'(bus4.in_ready), 64'd0);
    wait_done4("t4b");
    chk("t4b_sum", 64'(bus4.out_sum), 64'h0000_0003);

    // 5: reset in the middle of RUN
    @(negedge clk);
    chk("t5_in_ready", 64'(bus4.in_ready), 64'd1);
    bus4.in_valid = 1'b1;
    bus4.in_a     = 32'hFFFF_FFFF;
    bus4.in_b     = 32'h0000_0001;
    bus4.in_cin   = 1'b0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus4.out_valid), 64'd0);
    chk("t5_rst_in_ready", 64'(bus4.in_ready), 64'd0);
    chk("t5_rst_sum", 64'(bus4.out_sum), 64'd0);
    chk("t5_rst_cout", 64'(bus4.out_cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_valid", 64'(bus4.out_valid), 64'd0);
    end
    accept4("t5b", 32'h1234_5678, 32'h1111_1111, 1'b0);
    chk("t5b_sum", 64'(bus4.out_sum), 64'h2345_6789);
    chk("t5b_cout", 64'(bus4.out_cout), 64'd0);
    chk("t5b_ovf", 64'(bus4.out_ovf), 64'd0);

    // 6: single-slice instance
    @(negedge clk);
    chk("t6_in_ready", 64'(bus1.in_ready), 64'd1);
    bus1.in_valid = 1'b1;
    bus1.in_a     = 8'hFF;
    bus1.in_b     = 8'h01;
    bus1.in_cin   = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    chk("t6_valid_lo", 64'(bus1.out_valid), 64'd0);
    @(negedge clk);
    chk("t6_valid_hi", 64'(bus1.out_valid), 64'd1);
    chk("t6_sum", 64'(bus1.out_sum), 64'h01);
    chk("t6_cout", 64'(bus1.out_cout), 64'd1);
    chk("t6_ovf", 64'(bus1.out_ovf), 64'd0);
    @(negedge clk);
    chk("t6_valid_drop", 64'(bus1.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
